// File: rtl/alu_ctrl_sequencer.sv
// ALU control decoder with a small sequencer for multi-cycle RV32M operations.
// Decodes the main-decoder ALUOp plus instruction fields into a 5-bit ALU
// operation code, registers it, and holds it steady (with stall asserted)
// while a multiply or divide unit is working.

module alu_ctrl_sequencer #(
    parameter int M_EXT   = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       flush,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    input  logic       op_5,
    output logic [4:0] alu_ctrl,
    output logic       ctrl_valid,
    output logic       stall,
    output logic       mdu_done,
    output logic       illegal
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SLTU = 5'd6;
    localparam logic [4:0] OP_SLL  = 5'd7;
    localparam logic [4:0] OP_SRL  = 5'd8;
    localparam logic [4:0] OP_SRA  = 5'd9;

    // Counter preload: the op occupies LAT cycles, the last one being the done cycle.
    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic [4:0] alu_ctrl_r;
    logic [4:0] alu_ctrl_nxt_s;
    logic       ctrl_valid_r;
    logic       ctrl_valid_nxt_s;
    logic       illegal_r;
    logic       illegal_nxt_s;

    logic [4:0] dec_code_s;
    logic       dec_ill_s;
    logic       dec_mdu_s;
    logic       stall_s;
    logic       mdu_done_s;

    // Instruction-field decode into an operation code, illegal flag and multi-cycle flag.
    always_comb begin
        dec_code_s = OP_ADD;
        dec_ill_s  = 1'b0;
        dec_mdu_s  = 1'b0;
        case (alu_op)
            2'b00: dec_code_s = OP_ADD;
            2'b01: dec_code_s = OP_SUB;
            2'b11: begin
                case (funct3)
                    3'b000, 3'b001: dec_code_s = OP_SUB;
                    3'b100, 3'b101: dec_code_s = OP_SLT;
                    3'b110, 3'b111: dec_code_s = OP_SLTU;
                    default: begin
                        // funct3 010/011 are not branch encodings
                        dec_code_s = OP_ADD;
                        dec_ill_s  = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                if (op_5 && funct7_0) begin
                    if (M_EXT != 0) begin
                        // MUL..REMU occupy codes 16..23 in funct3 order
                        dec_code_s = {2'b10, funct3};
                        dec_mdu_s  = 1'b1;
                    end else begin
                        dec_code_s = OP_ADD;
                        dec_ill_s  = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000: begin
                            if (op_5 && funct7_5) begin
                                dec_code_s = OP_SUB;
                            end else begin
                                dec_code_s = OP_ADD;
                            end
                        end
                        3'b001: dec_code_s = OP_SLL;
                        3'b010: dec_code_s = OP_SLT;
                        3'b011: dec_code_s = OP_SLTU;
                        3'b100: dec_code_s = OP_XOR;
                        3'b101: begin
                            if (funct7_5) begin
                                dec_code_s = OP_SRA;
                            end else begin
                                dec_code_s = OP_SRL;
                            end
                        end
                        3'b110: dec_code_s = OP_OR;
                        3'b111: dec_code_s = OP_AND;
                        default: dec_code_s = OP_ADD;
                    endcase
                end
            end
            default: dec_code_s = OP_ADD;
        endcase
    end

    // Handshake outputs derived purely from the registered state and counter.
    always_comb begin
        stall_s    = 1'b0;
        mdu_done_s = 1'b0;
        case (state_r)
            BUSY: begin
                stall_s    = (cnt_r != 8'd0);
                mdu_done_s = (cnt_r == 8'd0);
            end
            IDLE: begin
                stall_s    = 1'b0;
                mdu_done_s = 1'b0;
            end
            default: begin
                stall_s    = 1'b0;
                mdu_done_s = 1'b0;
            end
        endcase
    end

    // Next-state: flush beats a new request; a request is taken whenever stall is low.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        alu_ctrl_nxt_s   = alu_ctrl_r;
        ctrl_valid_nxt_s = ctrl_valid_r;
        illegal_nxt_s    = illegal_r;
        if (flush) begin
            state_nxt_s      = IDLE;
            cnt_nxt_s        = 8'd0;
            alu_ctrl_nxt_s   = OP_ADD;
            ctrl_valid_nxt_s = 1'b0;
            illegal_nxt_s    = 1'b0;
        end else if (in_valid && !stall_s) begin
            alu_ctrl_nxt_s   = dec_code_s;
            illegal_nxt_s    = dec_ill_s;
            ctrl_valid_nxt_s = 1'b1;
            if (dec_mdu_s) begin
                state_nxt_s = BUSY;
                cnt_nxt_s   = funct3[2] ? DIV_CNT : MUL_CNT;
            end else begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 8'd0;
            end
        end else begin
            case (state_r)
                BUSY: begin
                    if (cnt_r != 8'd0) begin
                        cnt_nxt_s = cnt_r - 8'd1;
                    end else begin
                        // done cycle with no follow-on request: drop back to idle
                        state_nxt_s      = IDLE;
                        ctrl_valid_nxt_s = 1'b0;
                        illegal_nxt_s    = 1'b0;
                    end
                end
                IDLE: begin
                    ctrl_valid_nxt_s = 1'b0;
                    illegal_nxt_s    = 1'b0;
                end
                default: begin
                    state_nxt_s      = IDLE;
                    cnt_nxt_s        = 8'd0;
                    ctrl_valid_nxt_s = 1'b0;
                    illegal_nxt_s    = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered decode outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            alu_ctrl_r   <= OP_ADD;
            ctrl_valid_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            alu_ctrl_r   <= alu_ctrl_nxt_s;
            ctrl_valid_r <= ctrl_valid_nxt_s;
            illegal_r    <= illegal_nxt_s;
        end
    end

    assign alu_ctrl   = alu_ctrl_r;
    assign ctrl_valid = ctrl_valid_r;
    assign illegal    = illegal_r;
    assign stall      = stall_s;
    assign mdu_done   = mdu_done_s;

endmodule
